// File: rtl/ppm_modulator.sv
// 4-PPM line modulator: latches a 2-bit symbol and emits one pulse in the selected slot of a 4-slot frame.
// Optional guard slot after slot 3 when PPM_GUARD_EN is defined.
module ppm_modulator #(
  parameter int SLOT_CYCLES  = 4,
  parameter int PULSE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       ppm_out,
  output logic       busy,
  output logic       sym_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_CYCLES - 1);

`ifdef PPM_GUARD_EN
  typedef enum logic [1:0] {IDLE, SLOT, GUARD} state_t;
`else
  typedef enum logic [0:0] {IDLE, SLOT} state_t;
`endif

  state_t          state, n_state;
  logic [CW-1:0]   cnt, n_cnt;
  logic [1:0]      slot, n_slot;
  logic [1:0]      sym, n_sym;
  logic            xfer, slot_end, frame_end;
  logic            n_last, n_ppm;

  always_comb begin
    xfer     = sym_valid & sym_ready;
    slot_end = (cnt == CNT_MAX);
    n_state  = state;
    n_slot   = slot;
    n_sym    = sym;
    n_cnt    = slot_end ? '0 : cnt + 1'b1;
`ifdef PPM_GUARD_EN
    frame_end = (state == GUARD) && slot_end;
`else
    frame_end = (state == SLOT) && (slot == 2'd3) && slot_end;
`endif

    case (state)
      IDLE: begin
        n_cnt = '0;
        if (xfer) begin
          n_state = SLOT;
          n_slot  = 2'd0;
          n_sym   = sym_in;
        end
      end
      SLOT: begin
        if (slot_end && slot != 2'd3) n_slot = slot + 2'd1;
`ifdef PPM_GUARD_EN
        if (slot_end && slot == 2'd3) n_state = GUARD;
`endif
      end
      default: ;
    endcase

    // Frame end either re-arms immediately (back-to-back) or drops to IDLE.
    if (frame_end) begin
      n_slot  = 2'd0;
      n_state = xfer ? SLOT : IDLE;
      if (xfer) n_sym = sym_in;
    end

`ifdef PPM_GUARD_EN
    n_last = (n_state == GUARD) && (n_cnt == CNT_MAX);
`else
    n_last = (n_state == SLOT) && (n_slot == 2'd3) && (n_cnt == CNT_MAX);
`endif
    n_ppm = (n_state == SLOT) && (n_slot == n_sym) &&
            ({{(32-CW){1'b0}}, n_cnt} < 32'(PULSE_CYCLES));
  end

  // Outputs are computed from next-state values so each flop lines up with its frame cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      slot      <= 2'd0;
      sym       <= 2'd0;
      ppm_out   <= 1'b0;
      busy      <= 1'b0;
      sym_done  <= 1'b0;
      sym_ready <= 1'b0;
    end else begin
      state     <= n_state;
      cnt       <= n_cnt;
      slot      <= n_slot;
      sym       <= n_sym;
      ppm_out   <= n_ppm;
      busy      <= (n_state != IDLE);
      sym_done  <= n_last;
      sym_ready <= (n_state == IDLE) || n_last;
    end
  end

endmodule

// File: tb/tb_ppm_modulator.sv
// Bench for ppm_modulator: two instances (default and 8/3 slot geometry) checked every cycle
// against a frame-cycle reference model, with directed and random symbol streams.
module tb_ppm_modulator;

  logic       clk, rst_n;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic [1:0] rdy_v, ppm_v, busy_v, done_v;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ppm_modulator dut0 (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(rdy_v[0]), .ppm_out(ppm_v[0]), .busy(busy_v[0]), .sym_done(done_v[0])
  );

  ppm_modulator #(.SLOT_CYCLES(8), .PULSE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(rdy_v[1]), .ppm_out(ppm_v[1]), .busy(busy_v[1]), .sym_done(done_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PPM_GUARD_EN
  localparam int NSLOTS = 5;
`else
  localparam int NSLOTS = 4;
`endif

  // Reference model: frame described only by active flag, frame cycle k and symbol s.
  int sc [2] = '{4, 8};
  int pc [2] = '{1, 3};
  bit act [2];
  bit rdy_ok [2];
  bit last_xf [2];
  int k [2];
  int s [2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; rdy_ok[i] = 0; last_xf[i] = 0; k[i] = 0; s[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int f;
      logic e_ppm, e_rdy, e_done;
      f      = NSLOTS * sc[i];
      e_ppm  = act[i] && (k[i] / sc[i] == s[i]) && (k[i] % sc[i] < pc[i]);
      e_rdy  = rdy_ok[i] && (!act[i] || k[i] == f - 1);
      e_done = act[i] && (k[i] == f - 1);
      chk($sformatf("ppm_out[%0d]@%0d", i, cyc), ppm_v[i], e_ppm);
      chk($sformatf("busy[%0d]@%0d", i, cyc), busy_v[i], act[i]);
      chk($sformatf("sym_ready[%0d]@%0d", i, cyc), rdy_v[i], e_rdy);
      chk($sformatf("sym_done[%0d]@%0d", i, cyc), done_v[i], e_done);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 0; rdy_ok[i] = 0; last_xf[i] = 0; k[i] = 0;
      end else begin
        int f;
        bit pre, xf;
        f   = NSLOTS * sc[i];
        pre = rdy_ok[i] && (!act[i] || k[i] == f - 1);
        xf  = sym_valid && pre;
        if (act[i]) begin
          k[i]++;
          if (k[i] == f) act[i] = 0;
        end
        if (xf) begin
          act[i] = 1; k[i] = 0; s[i] = int'(sym_in);
        end
        rdy_ok[i]  = 1;
        last_xf[i] = xf;
      end
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    bit got;
    int n;
    logic [1:0] seq [3];
    seq = '{2'd0, 2'd3, 2'd1};

    rst_n = 1'b0; sym_valid = 1'b0; sym_in = 2'd0;
    model_reset();
    #12;
    check_all();
    steps(2);
    #2 rst_n = 1'b1;
    step();
    steps(2);

    // Single symbol 2, then let both frames drain.
    sym_in = 2'b10; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0; sym_in = 2'b01;
    steps(40);

    // Back-to-back 0,3,1 on the default instance with sym_valid held high.
    sym_valid = 1'b1;
    for (int q = 0; q < 3; q++) begin
      sym_in = seq[q];
      got = 0; n = 0;
      while (!got && n < 40) begin
        step();
        got = last_xf[0];
        n++;
      end
      chk($sformatf("b2b_xfer%0d", q), got, 1'b1);
    end
    sym_valid = 1'b0;
    steps(40);

    // Symbol 3 on both (8/3 instance: pulse at 24..26).
    sym_in = 2'b11; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    steps(40);

    // Symbol toggling while not ready must not move the pulse.
    sym_in = 2'b01; sym_valid = 1'b1;
    step();
    for (int j = 0; j < 10; j++) begin
      sym_in = 2'($urandom_range(0, 3));
      step();
    end
    sym_valid = 1'b0;
    steps(40);

    // Random stream.
    for (int j = 0; j < 500; j++) begin
      sym_valid = ($urandom_range(0, 3) != 0);
      sym_in    = 2'($urandom_range(0, 3));
      step();
    end
    sym_valid = 1'b0;
    steps(40);

    // Reset at frame cycle 5 of symbol 1.
    sym_in = 2'b01; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    steps(5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    steps(2);
    #2 rst_n = 1'b1;
    step();
    steps(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
